// File: rtl/sm_rom_arbiter.sv
// Two-port arbiter in front of a two-word combinational instruction ROM.
// CPU has fixed priority; a saturating debug wait counter bounds debug stall time.
module sm_rom_arbiter #(
    parameter int SIZE     = 64,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        c_req,
    input  logic [31:0] c_addr,
    output logic        c_gnt,
    output logic        c_rvalid,
    output logic [31:0] c_rd0,
    output logic [31:0] c_rd1,
    output logic        c_err,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rd0,
    output logic [31:0] d_rd1,
    output logic        d_err,
    output logic [31:0] rom_a,
    input  logic [31:0] rom_rd0,
    input  logic [31:0] rom_rd1
);

    // MAX_WAIT=0 would give a zero-width counter; keep at least one bit.
    localparam int WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WW-1:0] WMAX    = WW'(MAX_WAIT);
    localparam logic [31:0]   ADDR_HI = 32'(SIZE - 2);

    logic [WW-1:0] wcnt_reg, wcnt_next;
    logic [31:0]   last_a_reg;
    logic          d_win;
    logic [31:0]   gnt_addr;
    logic          err_n;

    logic          c_rvalid_reg, c_err_reg, d_rvalid_reg, d_err_reg;
    logic [31:0]   c_rd0_reg, c_rd1_reg, d_rd0_reg, d_rd1_reg;

    always_comb begin
        d_win     = d_req && (wcnt_reg >= WMAX);
        d_gnt     = d_req && (d_win || !c_req);
        c_gnt     = c_req && !d_gnt;
        gnt_addr  = last_a_reg;
        if (d_gnt)
            gnt_addr = d_addr;
        else if (c_gnt)
            gnt_addr = c_addr;
        err_n     = gnt_addr > ADDR_HI;
        wcnt_next = '0;
        if (d_req && !d_gnt)
            wcnt_next = (wcnt_reg == WMAX) ? wcnt_reg : wcnt_reg + 1'b1;
    end

    assign rom_a = gnt_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt_reg   <= '0;
            last_a_reg <= '0;
        end else begin
            wcnt_reg <= wcnt_next;
            if (c_gnt || d_gnt)
                last_a_reg <= gnt_addr;
        end
    end

    // Response registers: out-of-range reads return zero data with err set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_rvalid_reg <= 1'b0;
            c_err_reg    <= 1'b0;
            c_rd0_reg    <= '0;
            c_rd1_reg    <= '0;
            d_rvalid_reg <= 1'b0;
            d_err_reg    <= 1'b0;
            d_rd0_reg    <= '0;
            d_rd1_reg    <= '0;
        end else begin
            c_rvalid_reg <= c_gnt;
            c_err_reg    <= c_gnt && err_n;
            if (c_gnt) begin
                c_rd0_reg <= err_n ? 32'd0 : rom_rd0;
                c_rd1_reg <= err_n ? 32'd0 : rom_rd1;
            end
            d_rvalid_reg <= d_gnt;
            d_err_reg    <= d_gnt && err_n;
            if (d_gnt) begin
                d_rd0_reg <= err_n ? 32'd0 : rom_rd0;
                d_rd1_reg <= err_n ? 32'd0 : rom_rd1;
            end
        end
    end

    assign c_rvalid = c_rvalid_reg;
    assign c_err    = c_err_reg;
    assign c_rd0    = c_rd0_reg;
    assign c_rd1    = c_rd1_reg;
    assign d_rvalid = d_rvalid_reg;
    assign d_err    = d_err_reg;
    assign d_rd0    = d_rd0_reg;
    assign d_rd1    = d_rd1_reg;

endmodule

// File: tb/tb_sm_rom_arbiter.sv
// Scoreboard bench for sm_rom_arbiter: default build plus a MAX_WAIT=0 build
// sharing the same request stimulus.
module tb_sm_rom_arbiter;

    localparam int SIZE = 64;
    localparam int MW   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        c_req = 1'b0, d_req = 1'b0;
    logic [31:0] c_addr = '0, d_addr = '0;
    logic        c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err;
    logic [31:0] c_rd0, c_rd1, d_rd0, d_rd1, rom_a, rom_rd0, rom_rd1;
    logic        c_gnt0, c_rvalid0, c_err0, d_gnt0, d_rvalid0, d_err0;
    logic [31:0] c_rd00, c_rd10, d_rd00, d_rd10, rom_a0, rom_rd00, rom_rd10;

    always #5 clk = ~clk;

    function automatic logic [31:0] romf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    assign rom_rd0  = romf(rom_a);
    assign rom_rd1  = romf(rom_a + 32'd1);
    assign rom_rd00 = romf(rom_a0);
    assign rom_rd10 = romf(rom_a0 + 32'd1);

    sm_rom_arbiter #(.SIZE(SIZE), .MAX_WAIT(MW)) u_dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_addr(c_addr), .c_gnt(c_gnt), .c_rvalid(c_rvalid),
        .c_rd0(c_rd0), .c_rd1(c_rd1), .c_err(c_err),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rd0(d_rd0), .d_rd1(d_rd1), .d_err(d_err),
        .rom_a(rom_a), .rom_rd0(rom_rd0), .rom_rd1(rom_rd1)
    );

    sm_rom_arbiter #(.SIZE(SIZE), .MAX_WAIT(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_addr(c_addr), .c_gnt(c_gnt0), .c_rvalid(c_rvalid0),
        .c_rd0(c_rd00), .c_rd1(c_rd10), .c_err(c_err0),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt0), .d_rvalid(d_rvalid0),
        .d_rd0(d_rd00), .d_rd1(d_rd10), .d_err(d_err0),
        .rom_a(rom_a0), .rom_rd0(rom_rd00), .rom_rd1(rom_rd10)
    );

    typedef struct {
        logic        err;
        logic [31:0] d0;
        logic [31:0] d1;
    } rsp_t;

    rsp_t        cq[$];
    rsp_t        dq[$];
    int          total = 0;
    int          bad   = 0;
    int          m_wcnt = 0;
    logic [31:0] m_last = '0;
    logic [31:0] c_h0 = '0, c_h1 = '0, d_h0 = '0, d_h1 = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic rsp_t mk(input logic [31:0] a);
        rsp_t r;
        r.err = a > 32'(SIZE - 2);
        r.d0  = r.err ? 32'd0 : romf(a);
        r.d1  = r.err ? 32'd0 : romf(a + 32'd1);
        return r;
    endfunction

    task automatic model_reset();
        cq.delete();
        dq.delete();
        m_wcnt = 0;
        m_last = '0;
        c_h0 = '0; c_h1 = '0; d_h0 = '0; d_h1 = '0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_c_rvalid"}, c_rvalid, 0);
        chk({tag, "_c_err"}, c_err, 0);
        chk({tag, "_c_rd"}, {c_rd0, c_rd1}, 0);
        chk({tag, "_d_rvalid"}, d_rvalid, 0);
        chk({tag, "_d_err"}, d_err, 0);
        chk({tag, "_d_rd"}, {d_rd0, d_rd1}, 0);
    endtask

    // Checks the response side of one port against its scoreboard queue.
    task automatic chk_rsp(input bit is_d, input logic exp_rv);
        rsp_t        r;
        logic        rv, er;
        logic [31:0] r0, r1;
        string       p;
        p  = is_d ? "d" : "c";
        rv = is_d ? d_rvalid : c_rvalid;
        er = is_d ? d_err : c_err;
        r0 = is_d ? d_rd0 : c_rd0;
        r1 = is_d ? d_rd1 : c_rd1;
        chk({p, "_rvalid"}, rv, exp_rv);
        if (rv) begin
            if ((is_d ? dq.size() : cq.size()) == 0) begin
                chk({p, "_q_underflow"}, 1, 0);
            end else begin
                r = is_d ? dq.pop_front() : cq.pop_front();
                chk({p, "_err"}, er, r.err);
                chk({p, "_rd0"}, r0, r.d0);
                chk({p, "_rd1"}, r1, r.d1);
                if (is_d) begin d_h0 = r.d0; d_h1 = r.d1; end
                else begin c_h0 = r.d0; c_h1 = r.d1; end
            end
        end else begin
            chk({p, "_err_idle"}, er, 0);
            chk({p, "_rd_hold"}, {r0, r1}, is_d ? {d_h0, d_h1} : {c_h0, c_h1});
        end
    endtask

    // One clock cycle of stimulus; entered and left just after a rising edge.
    task automatic cyc(input logic cr, input logic [31:0] ca,
                       input logic dr, input logic [31:0] da);
        logic        edg, ecg;
        logic [31:0] ga;
        c_req = cr; c_addr = ca; d_req = dr; d_addr = da;
        #1;
        edg = dr && (m_wcnt >= MW || !cr);
        ecg = cr && !edg;
        ga  = edg ? da : (ecg ? ca : m_last);
        chk("c_gnt", c_gnt, ecg);
        chk("d_gnt", d_gnt, edg);
        chk("rom_a", rom_a, ga);
        chk("c_gnt_mw0", c_gnt0, cr && !dr);
        chk("d_gnt_mw0", d_gnt0, dr);
        if (ecg) cq.push_back(mk(ca));
        if (edg) dq.push_back(mk(da));
        if (ecg || edg) m_last = ga;
        m_wcnt = (dr && !edg) ? ((m_wcnt < MW) ? m_wcnt + 1 : MW) : 0;
        $display("txn t=%0t c_req=%0b c_addr=%0h d_req=%0b d_addr=%0h gnt=%s",
                 $time, cr, ca, dr, da, edg ? "D" : (ecg ? "C" : "-"));
        @(posedge clk);
        #1;
        chk_rsp(1'b0, ecg);
        chk_rsp(1'b1, edg);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        model_reset();

        // Single CPU read, then idle cycle.
        cyc(1, 32'd5, 0, 0);
        cyc(0, 0, 0, 0);

        // Both requesting: C,C,C,C,D repeating.
        for (int i = 0; i < 12; i++)
            cyc(1, 32'(i), 1, 32'(40 + i));
        cyc(0, 0, 0, 0);

        // Debug alone, range boundaries.
        cyc(0, 0, 1, 32'd63);
        cyc(0, 0, 1, 32'd62);
        cyc(0, 0, 1, 32'hFFFF_FFFF);
        cyc(1, 32'd64, 0, 0);
        cyc(1, 32'd0, 0, 0);
        cyc(0, 0, 0, 0);

        // Debug request withdrawn before being granted clears the wait count.
        cyc(1, 32'd1, 1, 32'd2);
        cyc(1, 32'd1, 1, 32'd2);
        cyc(1, 32'd1, 0, 0);
        for (int i = 0; i < 6; i++)
            cyc(1, 32'd3, 1, 32'd4);

        // Random traffic.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 70));
            b = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 70));
            cyc(1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)), b);
        end
        cyc(0, 0, 0, 0);

        // Asynchronous reset mid-cycle clears outputs before the next edge.
        cyc(1, 32'd9, 1, 32'd10);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("async_rst");
        c_req = 1'b0; d_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // Grant at addr 7 discarded by a reset held across the edge.
        c_req = 1'b1; c_addr = 32'd7;
        #1;
        chk("rst_drop_gnt", c_gnt, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_drop_rv0", c_rvalid, 0);
        c_req = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_drop_rv1", c_rvalid, 0);
        model_reset();
        cyc(1, 32'd7, 0, 0);
        cyc(0, 0, 0, 0);

        chk("c_q_left", 64'(cq.size()), 0);
        chk("d_q_left", 64'(dq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
